// File: rtl/residue_chk_pkg.sv
// rtl/residue_chk_pkg.sv - shared FSM encoding and sizing helpers for the residue check scheduler
package residue_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic logic [63:0] mod_mask(input int bits);
    if (bits >= 64) return '1;
    return (64'd1 << bits) - 64'd1;
  endfunction

  // Index width; a single requester still needs a 1-bit id.
  function automatic int id_width(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter searching upward from a priority pointer with wrap
module rr_arbiter
  import residue_chk_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int ID_W = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    pointer,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any_grant
);

  always_comb begin
    int idx;
    logic [ID_W-1:0] sel;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = 0;
    sel       = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      // pointer is always below NUM_REQ, so one subtraction is enough to wrap
      idx = int'(pointer) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sel = ID_W'(idx);
      if (!any_grant && req[sel]) begin
        any_grant  = 1'b1;
        grant[sel] = 1'b1;
        grant_idx  = sel;
      end
    end
  end

endmodule

// File: rtl/residue_check_scheduler.sv
// rtl/residue_check_scheduler.sv - shared mod-2^MOD_BITS residue checker with round-robin
// request scheduling, 2-stage compare pipeline and sticky error bookkeeping
module residue_check_scheduler
  import residue_chk_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 16,
  parameter int MOD_BITS  = 4,
  parameter int ERR_CNT_W = 8,
  localparam int ID_W = id_width(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      clr_err,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ*DATA_W-1:0] req_pred,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      busy,
  output logic                      chk_valid,
  output logic [ID_W-1:0]           chk_id,
  output logic [DATA_W-1:0]         chk_residue,
  output logic                      chk_error,
  output logic                      err_sticky,
  output logic [ID_W-1:0]           err_first_id,
  output logic [ERR_CNT_W-1:0]      err_count
);

  localparam logic [63:0]       MASK64 = mod_mask(MOD_BITS);
  localparam logic [DATA_W-1:0] MASK   = MASK64[DATA_W-1:0];

  state_t              state;
  logic [ID_W-1:0]     ptr;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_idx;
  logic                any_grant;
  logic                accept;
  logic [DATA_W-1:0]   sel_data;
  logic [DATA_W-1:0]   sel_pred;

  logic                s1_valid;
  logic [ID_W-1:0]     s1_id;
  logic [DATA_W-1:0]   s1_residue;
  logic [DATA_W-1:0]   s1_pred;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (req_valid),
    .pointer   (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  assign req_ready = (state == ST_RUN) ? grant : '0;
  assign accept    = (state == ST_RUN) && any_grant;
  assign busy      = (state != ST_IDLE) || s1_valid || chk_valid;

  always_comb begin
    sel_data = '0;
    sel_pred = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_data = req_data[i*DATA_W +: DATA_W];
        sel_pred = req_pred[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      ptr   <= '0;
    end else begin
      case (state)
        ST_IDLE:  if (enable) state <= ST_RUN;
        ST_RUN:   if (!enable) state <= ST_DRAIN;
        ST_DRAIN: begin
          if (enable) state <= ST_RUN;
          else if (!s1_valid && !chk_valid) state <= ST_IDLE;
        end
        default:  state <= ST_IDLE;
      endcase
      if (accept) ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_id       <= '0;
      s1_residue  <= '0;
      s1_pred     <= '0;
      chk_valid   <= 1'b0;
      chk_id      <= '0;
      chk_residue <= '0;
      chk_error   <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_id      <= grant_idx;
        s1_residue <= sel_data & MASK;
        s1_pred    <= sel_pred;
      end
      chk_valid <= s1_valid;
      chk_error <= s1_valid && (s1_residue != s1_pred);
      if (s1_valid) begin
        chk_id      <= s1_id;
        chk_residue <= s1_residue;
      end
    end
  end

  // A new error in the clearing cycle restarts the bookkeeping from that error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sticky   <= 1'b0;
      err_first_id <= '0;
      err_count    <= '0;
    end else if (chk_valid && chk_error) begin
      err_sticky <= 1'b1;
      if (!err_sticky || clr_err) err_first_id <= chk_id;
      if (clr_err) err_count <= ERR_CNT_W'(1);
      else if (!(&err_count)) err_count <= err_count + ERR_CNT_W'(1);
    end else if (clr_err) begin
      err_sticky   <= 1'b0;
      err_first_id <= '0;
      err_count    <= '0;
    end
  end

endmodule
